key_pot_responder: RTL and testbench
====================================

Name: key_pot_responder

Overview:
- Emulates the external keyboard matrix and paddle RC networks that the POKEY I/O control block scans.
- Accepts key-press requests from the board side through a valid/ready handshake. Drives kr1_L/kr2_L in response to the key_scan_L sweep.
- Generates pot_scan edges, timed by latched paddle values, after the dump transistors (pot_rel_0/1) release.
- Sits between the FPGA input logic (buttons/host) and POKEY, enabling closed-loop simulation and hardware demos.

Parameters:
- HOLD_SCANS, 4: full 16-step key_scan_L sweeps a key is held pressed.
- GAP_SCANS, 2: full sweeps of forced release after a press, before a new request is accepted.
- LINE_DIV, 1: o2 cycles per pot count increment (1 = one count per o2, matching the POKEY pot counter).

Ports:
- o2  input  1  system clock; all state updates on posedge.
- rst_L  input  1  synchronous active-low reset, sampled on posedge o2.
- key_valid  input  1  board side requests a key press.
- key_code  input  4  matrix index 0-15 to press; sampled when key_valid&&key_ready.
- key_shift  input  1  modifier held with the key; sampled with key_code.
- key_ready  output  1  responder idle and able to accept a request.
- key_scan_L  input  4  active-low scan index from POKEY.
- kr1_L  output  1  active-low key-return line.
- kr2_L  output  1  active-low modifier-return line.
- paddle0  input  8  target count for pot 0.
- paddle1  input  8  target count for pot 1.
- pot_rel_0  input  1  dump transistor 0 on (capacitor discharged).
- pot_rel_1  input  1  dump transistor 1 on.
- pot_scan  output  8  comparator outputs to POKEY; bits [7:2] constant 0.

Behaviour:
- Reset (rst_L=0 at posedge), all values take effect on that edge:
  - FSM goes to IDLE; key_ready=1; kr1_L=1; kr2_L=1.
  - Sweep counter=0; both pot counters=0; pot_scan=8'h00; latched paddles=0.
- Reset mid-press releases the key in the same cycle and discards the request.
- Scan index is ~key_scan_L. A sweep boundary is a posedge at which the index equals 15; this marks the end of a sweep.
- Key FSM:
  - IDLE: key_ready=1. On key_valid&&key_ready, latch key_code/key_shift, clear sweep counter and go to PRESS. key_ready drops the next cycle.
  - PRESS: key_ready=0. At each sweep boundary increment the sweep counter. At the boundary where count reaches HOLD_SCANS, clear the counter and go to GAP.
  - GAP: kr1_L/kr2_L forced high. Count sweep boundaries to GAP_SCANS, then go to IDLE.
- The first partial sweep after entering PRESS counts as one sweep if it reaches index 15.
- HOLD_SCANS and GAP_SCANS of 0 are treated as 1.
- kr1_L is combinational, so POKEY samples it on the same edge as the matching scan index:
  - kr1_L = ~(state==PRESS && ~key_scan_L==latched_code).
  - Zero-cycle path from key_scan_L; no registers on it.
- kr2_L = ~(state==PRESS && latched_shift). It is asserted for the whole PRESS, independent of scan index.
- key_valid held high across GAP is not accepted until IDLE. The handshake is accepted only in IDLE.
- Pot channel n (n=0,1), identical and independent:
  - While pot_rel_n=1: counter=0, pot_scan[n]=0, latched_paddle_n<=paddle_n every cycle.
  - On release (pot_rel_n=0): the prescaler counts o2 cycles to LINE_DIV. On each terminal count the counter increments, saturating at 255.
  - pot_scan[n] is registered: 1 when counter >= latched_paddle_n. With paddle 0 it goes high on the first posedge after release.
  - Once high, pot_scan[n] stays high until pot_rel_n reasserts.
  - Paddle input changes after release are ignored until the next dump.
  - pot_rel_n reasserted mid-count clears the counter and pot_scan[n] on that edge.

Decomposition:
- Shared package (pokey_pkg): key FSM state encoding (IDLE/PRESS/GAP), SCAN_LEN=16, POT_MAX=8'd255, pot count width 8.
- One sub-module is natural: pot_channel (prescaler, saturating counter, paddle latch, comparator flop), instantiated twice.

Test Plan:
- Reset with key_valid=1, pot_rel_0=0: during reset key_ready=1, kr1_L=1, kr2_L=1, pot_scan=0. After release, key_ready=1 and the request is accepted on the first cycle.
- Request key_code=5, key_shift=0, HOLD_SCANS=4, free-running sweep: kr1_L=0 exactly on cycles where key_scan_L=4'hA, for 4 sweeps. Then GAP for 2 sweeps with kr1_L=1, then key_ready=1.
- key_code=12, key_shift=1: kr2_L=0 throughout PRESS. kr1_L low only at key_scan_L=4'h3. Back-to-back key_valid is not accepted until GAP ends.
- paddle0=8'd40, LINE_DIV=1, pot_rel_0 high 3 cycles then low: pot_scan[0] rises 41 posedges after the release edge (counter 40 reached and registered). pot_scan[1] is unaffected.
- paddle1=8'd0 changed to 8'd200 after release: pot_scan[1] high on the first posedge after release. It is cleared when pot_rel_1 reasserts; the next cycle then uses 200.
- Assert rst_L=0 mid-PRESS and mid-pot-count: kr1_L=1 and pot_scan=0 the same edge. After reset, the FSM is IDLE and counters are 0.

Source files
------------

// File: rtl/key_pot_responder_pkg.sv
// +----------------------------------------------------------------------+
// | key_pot_responder_pkg: shared types/constants for the key/pot model  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package key_pot_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } key_state_t;

  localparam int             SCAN_LEN  = 16;
  localparam logic [3:0]     SCAN_LAST = 4'(SCAN_LEN - 1);
  localparam int             POT_W     = 8;
  localparam logic [POT_W-1:0] POT_MAX = 8'd255;

  function automatic logic [POT_W-1:0] pot_inc(input logic [POT_W-1:0] v);
    return (v == POT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_pot_responder_pot_channel.sv
// +----------------------------------------------------------------------+
// | pot_channel: paddle RC emulation - prescaled saturating counter      |
// | compared against a paddle value latched while the cap is dumped.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module pot_channel
  import key_pot_responder_pkg::*;
#(
  parameter int LINE_DIV = 1
) (
  input  logic             o2,
  input  logic             rst_L,
  input  logic             pot_rel,
  input  logic [POT_W-1:0] paddle,
  output logic             scan
);

  localparam int             DIV_EFF  = (LINE_DIV < 1) ? 1 : LINE_DIV;
  localparam int             PRE_W    = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_EFF - 1);

  logic [PRE_W-1:0] r_pre;
  logic [POT_W-1:0] r_count;
  logic [POT_W-1:0] r_latch;
  logic             r_scan;

  always_ff @(posedge o2) begin
    if (!rst_L) begin
      r_pre   <= '0;
      r_count <= '0;
      r_latch <= '0;
      r_scan  <= 1'b0;
    end else if (pot_rel) begin
      r_pre   <= '0;
      r_count <= '0;
      r_latch <= paddle;
      r_scan  <= 1'b0;
    end else begin
      // Sticky: once the comparator trips it holds until the next dump.
      r_scan <= r_scan | (r_count >= r_latch);
      if (r_pre == PRE_LAST) begin
        r_pre   <= '0;
        r_count <= pot_inc(r_count);
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign scan = r_scan;

endmodule

`default_nettype wire

// File: rtl/key_pot_responder.sv
// +----------------------------------------------------------------------+
// | key_pot_responder: keyboard-matrix and paddle emulation for POKEY.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module key_pot_responder
  import key_pot_responder_pkg::*;
#(
  parameter int HOLD_SCANS = 4,
  parameter int GAP_SCANS  = 2,
  parameter int LINE_DIV   = 1
) (
  input  logic             o2,
  input  logic             rst_L,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             key_shift,
  output logic             key_ready,
  input  logic [3:0]       key_scan_L,
  output logic             kr1_L,
  output logic             kr2_L,
  input  logic [POT_W-1:0] paddle0,
  input  logic [POT_W-1:0] paddle1,
  input  logic             pot_rel_0,
  input  logic             pot_rel_1,
  output logic [7:0]       pot_scan
);

  localparam int          HOLD_EFF  = (HOLD_SCANS < 1) ? 1 : HOLD_SCANS;
  localparam int          GAP_EFF   = (GAP_SCANS < 1) ? 1 : GAP_SCANS;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_EFF - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_EFF - 1);

  key_state_t  r_state;
  logic [15:0] r_sweeps;
  logic [3:0]  r_code;
  logic        r_shift;
  logic        r_ready;
  logic [3:0]  w_idx;
  logic        w_boundary;
  logic        w_scan0;
  logic        w_scan1;

  assign w_idx      = ~key_scan_L;
  assign w_boundary = (w_idx == SCAN_LAST);

  always_ff @(posedge o2) begin
    if (!rst_L) begin
      r_state  <= ST_IDLE;
      r_sweeps <= '0;
      r_code   <= '0;
      r_shift  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (key_valid && r_ready) begin
            r_code   <= key_code;
            r_shift  <= key_shift;
            r_sweeps <= '0;
            r_ready  <= 1'b0;
            r_state  <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (w_boundary) begin
            if (r_sweeps == HOLD_LAST) begin
              r_sweeps <= '0;
              r_state  <= ST_GAP;
            end else begin
              r_sweeps <= r_sweeps + 16'd1;
            end
          end
        end
        ST_GAP: begin
          if (w_boundary) begin
            if (r_sweeps == GAP_LAST) begin
              r_sweeps <= '0;
              r_ready  <= 1'b1;
              r_state  <= ST_IDLE;
            end else begin
              r_sweeps <= r_sweeps + 16'd1;
            end
          end
        end
        default: begin
          r_sweeps <= '0;
          r_ready  <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // kr1_L must follow key_scan_L with no register so POKEY sees it on the same edge.
  assign kr1_L     = ~((r_state == ST_PRESS) && (w_idx == r_code));
  assign kr2_L     = ~((r_state == ST_PRESS) && r_shift);
  assign key_ready = r_ready;

  pot_channel #(.LINE_DIV(LINE_DIV)) u_pot0 (
    .o2      (o2),
    .rst_L   (rst_L),
    .pot_rel (pot_rel_0),
    .paddle  (paddle0),
    .scan    (w_scan0)
  );

  pot_channel #(.LINE_DIV(LINE_DIV)) u_pot1 (
    .o2      (o2),
    .rst_L   (rst_L),
    .pot_rel (pot_rel_1),
    .paddle  (paddle1),
    .scan    (w_scan1)
  );

  assign pot_scan = {6'b000000, w_scan1, w_scan0};

endmodule

`default_nettype wire

// File: tb/tb_key_pot_responder.sv
// +----------------------------------------------------------------------+
// | tb_key_pot_responder: directed + randomized bench with a sweep/edge  |
// | counting reference model.  Rev 1.0 - initial release                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_key_pot_responder;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int DIV  = 1;

  logic       o2, rst_L, key_valid, key_shift, key_ready, kr1_L, kr2_L;
  logic       pot_rel_0, pot_rel_1;
  logic [3:0] key_code, key_scan_L;
  logic [7:0] paddle0, paddle1, pot_scan;

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 0;

  key_pot_responder #(.HOLD_SCANS(HOLD), .GAP_SCANS(GAP), .LINE_DIV(DIV)) dut (
    .o2(o2), .rst_L(rst_L), .key_valid(key_valid), .key_code(key_code),
    .key_shift(key_shift), .key_ready(key_ready), .key_scan_L(key_scan_L),
    .kr1_L(kr1_L), .kr2_L(kr2_L), .paddle0(paddle0), .paddle1(paddle1),
    .pot_rel_0(pot_rel_0), .pot_rel_1(pot_rel_1), .pot_scan(pot_scan)
  );

  initial o2 = 1'b0;
  always #5 o2 = ~o2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweeps remaining in the press/gap, and released edges per pot.
  bit         m_ready;
  bit         m_shift;
  int         m_hold, m_gap, m_code;
  int         m_edges[2];
  int         m_latch[2];
  logic [3:0] m_idx;
  logic [1:0] m_rel;
  int         m_pad[2];

  function automatic int pot_exp(input int edges, input int latch);
    int c;
    if (edges < 1) return 0;
    c = (edges - 1) / DIV;
    if (c > 255) c = 255;
    return (c >= latch) ? 1 : 0;
  endfunction

  always @(posedge o2) begin
    m_idx = ~key_scan_L;
    m_rel = {pot_rel_1, pot_rel_0};
    m_pad[0] = int'(paddle0);
    m_pad[1] = int'(paddle1);
    if (!rst_L) begin
      m_ready = 1; m_hold = 0; m_gap = 0; m_code = 0; m_shift = 0;
      for (int n = 0; n < 2; n++) begin m_edges[n] = 0; m_latch[n] = 0; end
    end else begin
      if (m_ready && key_valid) begin
        m_ready = 0; m_hold = HOLD; m_code = int'(key_code); m_shift = key_shift;
      end else if (m_hold > 0) begin
        if (m_idx == 4'd15) begin
          m_hold--;
          if (m_hold == 0) m_gap = GAP;
        end
      end else if (m_gap > 0) begin
        if (m_idx == 4'd15) begin
          m_gap--;
          if (m_gap == 0) m_ready = 1;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (m_rel[n]) begin
          m_edges[n] = 0;
          m_latch[n] = m_pad[n];
        end else if (m_edges[n] < 100000) begin
          m_edges[n]++;
        end
      end
    end
  end

  always @(negedge o2) begin
    logic [3:0] ci;
    int e0, e1;
    if (cmp_en) begin
      ci = ~key_scan_L;
      e0 = pot_exp(m_edges[0], m_latch[0]);
      e1 = pot_exp(m_edges[1], m_latch[1]);
      chk("key_ready", key_ready, m_ready);
      chk("kr1_L", kr1_L, (m_hold > 0 && int'(ci) == m_code) ? 0 : 1);
      chk("kr2_L", kr2_L, (m_hold > 0 && m_shift) ? 0 : 1);
      chk("pot_scan", pot_scan, (e1 << 1) | e0);
    end
  end

  task automatic tick();
    @(posedge o2);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    key_valid = 1'b0;
    while (!key_ready && guard < 1000) begin
      key_scan_L = key_scan_L - 4'd1;
      tick();
      guard++;
    end
    chk("idle_reached", key_ready, 1);
  endtask

  // Presses at sweep index 0, then free-runs the sweep until key_ready returns.
  task automatic do_press(input logic [3:0] code, input logic shift, input bit hold_valid,
                          output int n, output int lows, output int k2);
    n = 0; lows = 0; k2 = 0;
    key_scan_L = 4'hF;
    key_valid  = 1'b1;
    key_code   = code;
    key_shift  = shift;
    tick();
    while (n < 400) begin
      n++;
      key_scan_L = ~(n[3:0]);
      if (!hold_valid) key_valid = 1'b0;
      #1;
      if (!kr1_L) lows++;
      if (!kr2_L) k2++;
      if (key_ready) break;
      tick();
    end
  endtask

  initial begin
    int n, lows, k2;
    rst_L = 0; key_valid = 1; key_code = 0; key_shift = 0; key_scan_L = 4'hF;
    pot_rel_0 = 0; pot_rel_1 = 1; paddle0 = 0; paddle1 = 0;
    cmp_en = 1;

    repeat (3) tick();
    chk("rst_key_ready", key_ready, 1);
    chk("rst_kr1", kr1_L, 1);
    chk("rst_kr2", kr2_L, 1);
    chk("rst_pot_scan", pot_scan, 0);
    rst_L = 1;
    tick();
    chk("accept_first_cycle", key_ready, 0);
    wait_idle();

    do_press(4'd5, 1'b0, 1'b0, n, lows, k2);
    chk("code5_cycles_to_ready", n, 96);
    chk("code5_kr1_lows", lows, 4);
    chk("code5_kr2_lows", k2, 0);

    do_press(4'd12, 1'b1, 1'b1, n, lows, k2);
    chk("code12_cycles_to_ready", n, 96);
    chk("code12_kr1_lows", lows, 4);
    chk("code12_kr2_lows", k2, 63);
    tick();
    chk("backtoback_accept", key_ready, 0);
    wait_idle();

    pot_rel_0 = 1; paddle0 = 8'd40;
    repeat (3) tick();
    pot_rel_0 = 0;
    for (int m = 1; m <= 41; m++) begin
      tick();
      if (m == 40) chk("pot0_before_40", pot_scan[0], 0);
      if (m == 41) begin
        chk("pot0_at_41", pot_scan[0], 1);
        chk("pot1_unaffected", pot_scan[1], 0);
      end
    end

    paddle1 = 8'd0;
    tick();
    pot_rel_1 = 0;
    tick();
    paddle1 = 8'd200;
    chk("pot1_zero_first_edge", pot_scan[1], 1);
    repeat (5) tick();
    chk("pot1_sticky", pot_scan[1], 1);
    pot_rel_1 = 1;
    tick();
    chk("pot1_dump_clear", pot_scan[1], 0);
    pot_rel_1 = 0;
    for (int m = 1; m <= 201; m++) begin
      tick();
      if (m == 200) chk("pot1_200_low", pot_scan[1], 0);
      if (m == 201) chk("pot1_200_high", pot_scan[1], 1);
    end

    pot_rel_0 = 1; paddle0 = 8'd100;
    tick();
    pot_rel_0 = 0;
    repeat (20) tick();
    key_scan_L = 4'hF; key_valid = 1; key_code = 4'd3;
    tick();
    key_valid = 0;
    key_scan_L = ~4'd3;
    #1;
    chk("kr1_before_rst", kr1_L, 0);
    rst_L = 0;
    tick();
    chk("rst_mid_kr1", kr1_L, 1);
    chk("rst_mid_pot", pot_scan, 0);
    chk("rst_mid_ready", key_ready, 1);
    rst_L = 1;
    tick();
    chk("pot0_after_rst", pot_scan[0], 1);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) < 7) key_scan_L = key_scan_L - 4'd1;
      else key_scan_L = 4'($urandom);
      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 4'($urandom);
      key_shift = 1'($urandom);
      if ($urandom_range(0, 63) == 0) pot_rel_0 = ~pot_rel_0;
      if ($urandom_range(0, 63) == 0) pot_rel_1 = ~pot_rel_1;
      paddle0 = 8'($urandom_range(0, 60));
      paddle1 = 8'($urandom_range(0, 60));
      rst_L   = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_L = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
